// File: rtl/sensor_frame_rx.sv
// ---------------------------------------------------------------------------
// sensor_frame_rx
//   Serial receiver for the sensor bus feeding the baggage drop datapath.
//   It deserialises one 48-bit frame (HEADER, S1, S2, S3, S4, CHK), MSB first
//   within each byte, and checks the header and the XOR checksum
//   (CHK = S1^S2^S3^S4). A good frame updates the registered sensor outputs.
//   A bad frame pulses frame_err and bumps a saturating error counter.
//
// Ports
//   clk         in   1      system clock, rising edge
//   rst         in   1      synchronous active-high reset
//   bit_valid   in   1      bit strobe, qualifies bit_in / frame_sync
//   bit_in      in   1      serial data bit
//   frame_sync  in   1      marks the first header bit (with bit_valid)
//   sensor1..4  out  8      last good sensor bytes
//   data_valid  out  1      a good frame has been received since reset
//   frame_ok    out  1      1-cycle pulse: good frame accepted
//   frame_err   out  1      1-cycle pulse: header or checksum mismatch
//   err_count   out  ERR_W  saturating count of frame_err pulses
// ---------------------------------------------------------------------------
module sensor_frame_rx #(
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             frame_sync,
  output logic [7:0]       sensor1,
  output logic [7:0]       sensor2,
  output logic [7:0]       sensor3,
  output logic [7:0]       sensor4,
  output logic             data_valid,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_CHK  = 2'd3;

  logic [1:0]       state_reg, state_next;
  logic [5:0]       bit_cnt_reg, bit_cnt_next;
  logic [7:0]       byte_reg, byte_next;
  logic [31:0]      staging_reg, staging_next;
  logic [7:0]       xor_reg, xor_next;
  logic             data_valid_reg, data_valid_next;
  logic             frame_ok_reg, frame_ok_next;
  logic             frame_err_reg, frame_err_next;
  logic [ERR_W-1:0] err_count_reg, err_count_next;
  logic             sensor_load;
  logic             err_event;
  logic [7:0]       byte_shift;

  // The byte as it will look once the current bit is shifted in; all
  // end-of-byte decisions are made on this value so that results land on
  // the edge that samples the last bit.
  assign byte_shift = {byte_reg[6:0], bit_in};

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    byte_next       = byte_reg;
    staging_next    = staging_reg;
    xor_next        = xor_reg;
    data_valid_next = data_valid_reg;
    frame_ok_next   = 1'b0;
    frame_err_next  = 1'b0;
    err_count_next  = err_count_reg;
    sensor_load     = 1'b0;
    err_event       = 1'b0;

    if (bit_valid) begin
      if (frame_sync) begin
        // Start (or restart) a frame from any state. An aborted frame is
        // dropped silently: no error pulse, outputs untouched.
        state_next   = ST_HDR;
        bit_cnt_next = 6'd1;
        byte_next    = {7'b0, bit_in};
        xor_next     = 8'h00;
      end else begin
        case (state_reg)
          ST_HDR: begin
            byte_next    = byte_shift;
            bit_cnt_next = bit_cnt_reg + 6'd1;
            if (bit_cnt_reg == 6'd7) begin
              if (byte_shift == HEADER) begin
                state_next = ST_DATA;
              end else begin
                state_next = ST_IDLE;
                err_event  = 1'b1;
              end
            end
          end
          ST_DATA: begin
            byte_next    = byte_shift;
            staging_next = {staging_reg[30:0], bit_in};
            bit_cnt_next = bit_cnt_reg + 6'd1;
            if (bit_cnt_reg[2:0] == 3'd7) begin
              xor_next = xor_reg ^ byte_shift;
              if (bit_cnt_reg == 6'd39) begin
                state_next = ST_CHK;
              end
            end
          end
          ST_CHK: begin
            byte_next    = byte_shift;
            bit_cnt_next = bit_cnt_reg + 6'd1;
            if (bit_cnt_reg == 6'd47) begin
              state_next = ST_IDLE;
              if (byte_shift == xor_reg) begin
                sensor_load     = 1'b1;
                data_valid_next = 1'b1;
                frame_ok_next   = 1'b1;
              end else begin
                err_event = 1'b1;
              end
            end
          end
          default: begin
            // IDLE: bits without frame_sync are discarded.
          end
        endcase
      end
    end

    if (err_event) begin
      frame_err_next = 1'b1;
      if (err_count_reg != {ERR_W{1'b1}}) begin
        err_count_next = err_count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      bit_cnt_reg    <= 6'd0;
      byte_reg       <= 8'h00;
      staging_reg    <= 32'h0;
      xor_reg        <= 8'h00;
      data_valid_reg <= 1'b0;
      frame_ok_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      byte_reg       <= byte_next;
      staging_reg    <= staging_next;
      xor_reg        <= xor_next;
      data_valid_reg <= data_valid_next;
      frame_ok_reg   <= frame_ok_next;
      frame_err_reg  <= frame_err_next;
      err_count_reg  <= err_count_next;
    end
  end

  // One output register per sensor byte; S1 arrived first so it sits in the
  // top byte of the staging register.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sensor
      logic [7:0] sensor_byte_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          sensor_byte_reg <= 8'h00;
        end else if (sensor_load) begin
          sensor_byte_reg <= staging_reg[31-8*gi -: 8];
        end
      end
    end
  endgenerate

  assign sensor1    = g_sensor[0].sensor_byte_reg;
  assign sensor2    = g_sensor[1].sensor_byte_reg;
  assign sensor3    = g_sensor[2].sensor_byte_reg;
  assign sensor4    = g_sensor[3].sensor_byte_reg;
  assign data_valid = data_valid_reg;
  assign frame_ok   = frame_ok_reg;
  assign frame_err  = frame_err_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_sensor_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_sensor_frame_rx
//   Directed bench for sensor_frame_rx. Frames are built as 48-bit words
//   {HEADER,S1,S2,S3,S4,CHK} with hand-computed checksums; outputs are
//   sampled 1 time unit after the rising edge that takes each bit.
// ---------------------------------------------------------------------------
module tb_sensor_frame_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] sensor1, sensor2, sensor3, sensor4;
  logic       data_valid, frame_ok, frame_err;
  logic [7:0] err_count;

  int vec_cnt = 0;
  int miscompare_cnt = 0;
  logic early_pulse;
  logic pulse_seen;

  wire [31:0] sensors = {sensor1, sensor2, sensor3, sensor4};

  sensor_frame_rx #(.HEADER(8'hA5), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .frame_sync(frame_sync), .sensor1(sensor1), .sensor2(sensor2),
    .sensor3(sensor3), .sensor4(sensor4), .data_valid(data_valid),
    .frame_ok(frame_ok), .frame_err(frame_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic send_bit(input logic sync, input logic b);
    bit_valid  = 1'b1;
    frame_sync = sync;
    bit_in     = b;
    @(posedge clk);
    #1;
    bit_valid  = 1'b0;
    frame_sync = 1'b0;
  endtask

  // Cycle without bit_valid; frame_sync/bit_in are driven with noise to show
  // they are ignored.
  task automatic gap_cycle();
    bit_valid  = 1'b0;
    frame_sync = 1'($urandom_range(0, 1));
    bit_in     = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    frame_sync = 1'b0;
  endtask

  // Send the first nbits of frame f (sync on bit 1); records any result pulse
  // seen before the final bit in early_pulse, and any pulse at all in pulse_seen.
  task automatic send_frame(input logic [47:0] f, input int nbits, input bit gaps);
    early_pulse = 1'b0;
    pulse_seen  = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) gap_cycle();
      send_bit(i == 0, f[47-i]);
      if (frame_ok || frame_err) begin
        pulse_seen = 1'b1;
        if (i < nbits - 1) early_pulse = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) begin
      send_bit(1'b0, 1'($urandom_range(0, 1)));
      if (frame_ok || frame_err) pulse_seen = 1'b1;
    end
  endtask

  initial begin
    do_reset();
    check("rst_sensors", sensors, 32'h0);
    check("rst_dv", data_valid, 1'b0);
    check("rst_ok", frame_ok, 1'b0);
    check("rst_err", frame_err, 1'b0);
    check("rst_cnt", err_count, 8'h00);

    // Bad checksum first, so sensors are still at reset.
    send_frame(48'hA5_10_20_30_40_41, 48, 1'b0);
    check("badchk_early", early_pulse, 1'b0);
    check("badchk_err", frame_err, 1'b1);
    check("badchk_ok", frame_ok, 1'b0);
    check("badchk_cnt", err_count, 8'h01);
    check("badchk_sensors", sensors, 32'h0);
    check("badchk_dv", data_valid, 1'b0);

    // Good frame, one bit per cycle.
    send_frame(48'hA5_10_20_30_40_40, 48, 1'b0);
    check("good_early", early_pulse, 1'b0);
    check("good_ok", frame_ok, 1'b1);
    check("good_err", frame_err, 1'b0);
    check("good_sensors", sensors, 32'h10203040);
    check("good_dv", data_valid, 1'b1);
    check("good_cnt", err_count, 8'h01);
    gap_cycle();
    check("good_ok_1cyc", frame_ok, 1'b0);

    // Bad header: error after bit 8, then 40 unsynced bits are ignored.
    send_frame(48'h5A_00_00_00_00_00, 8, 1'b0);
    check("hdr_err", frame_err, 1'b1);
    check("hdr_cnt", err_count, 8'h02);
    pulse_seen = 1'b0;
    idle_bits(40);
    check("hdr_ignored_pulse", pulse_seen, 1'b0);
    check("hdr_ignored_sensors", sensors, 32'h10203040);
    send_frame(48'hA5_11_22_33_44_44, 48, 1'b0);
    check("hdr_next_ok", frame_ok, 1'b1);
    check("hdr_next_sensors", sensors, 32'h11223344);

    // Good frame with random bit_valid gaps.
    send_frame(48'hA5_10_20_30_40_40, 48, 1'b1);
    check("gaps_early", early_pulse, 1'b0);
    check("gaps_ok", frame_ok, 1'b1);
    check("gaps_sensors", sensors, 32'h10203040);
    gap_cycle();
    check("gaps_ok_1cyc", frame_ok, 1'b0);

    // Resync at bit 20 of a frame; the new frame must be the only result.
    send_frame(48'hA5_FF_FF_FF_FF_00, 19, 1'b0);
    check("resync_abort_pulse", pulse_seen, 1'b0);
    send_frame(48'hA5_01_02_04_08_0F, 40, 1'b0);
    check("resync_mid_pulse", pulse_seen, 1'b0);
    check("resync_mid_sensors", sensors, 32'h10203040);
    send_frame(48'hA5_01_02_04_08_0F, 48, 1'b0);
    check("resync_ok", frame_ok, 1'b1);
    check("resync_sensors", sensors, 32'h01020408);
    check("resync_cnt", err_count, 8'h02);
    // Back-to-back frame, sync on the very next bit.
    send_frame(48'hA5_AA_BB_CC_DD_00, 48, 1'b0);
    check("b2b_early", early_pulse, 1'b0);
    check("b2b_ok", frame_ok, 1'b1);
    check("b2b_sensors", sensors, 32'hAABBCCDD);

    // Error counter saturation.
    do_reset();
    for (int k = 1; k <= 260; k++) begin
      send_frame(48'h5A_00_00_00_00_00, 8, 1'b0);
      if (k == 254) check("sat_254", err_count, 8'hFE);
      if (k == 255) check("sat_255", err_count, 8'hFF);
    end
    check("sat_260", err_count, 8'hFF);
    check("sat_err_pulse", frame_err, 1'b1);

    // Reset in the middle of a frame after a good one.
    send_frame(48'hA5_10_20_30_40_40, 48, 1'b0);
    check("prerst_sensors", sensors, 32'h10203040);
    send_frame(48'hA5_01_02_04_08_0F, 20, 1'b0);
    rst = 1'b1;
    send_bit(1'b0, 1'b1);
    rst = 1'b0;
    check("midrst_sensors", sensors, 32'h0);
    check("midrst_dv", data_valid, 1'b0);
    check("midrst_cnt", err_count, 8'h00);
    check("midrst_pulses", {frame_ok, frame_err}, 2'b00);
    pulse_seen = 1'b0;
    idle_bits(28);
    check("midrst_tail_pulse", pulse_seen, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule
